// File: rtl/uart_tx_pkg.sv
// Shared constants and FSM state encoding for the UART transmit framer.
package uart_tx_pkg;

  localparam int DATA_W               = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Bit-period timer: bit_tick is high on the last clock of each CLKS_PER_BIT period.
module uart_tx_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == CNT_LAST);

  // clear restarts the period so the first bit of a frame is full length
  always_ff @(posedge clk) begin
    if (rst || clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_frame_serializer
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_bit_in,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD_FLIP  = 1'(PARITY_ODD);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic              parity;
  logic [2:0]        bit_cnt;
  logic              stop_cnt;
  logic              bit_tick;
  logic              accept;
  logic              line_bit;

  assign accept = (state == S_IDLE) && tx_start;

  uart_tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .bit_tick(bit_tick)
  );

  always_comb begin
    line_bit = 1'b1;
    case (state)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = shift[0];
      S_PARITY: line_bit = parity;
      default:  line_bit = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      parity   <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_out  <= line_bit;
      tx_busy <= (state != S_IDLE);
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            shift    <= data_in;
            parity   <= parity_bit_in ^ ODD_FLIP;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_tick) state <= S_DATA;
        end
        S_DATA: begin
          if (bit_tick) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) state <= S_STOP;
        end
        S_STOP: begin
          if (bit_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state   <= S_IDLE;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Three framer configurations driven in parallel and checked against a frame-window model.
module tb_uart_tx_frame_serializer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       parity_bit_in = 1'b0;
  logic [2:0] tx_out, tx_busy, tx_done;

  always #5 clk = ~clk;

  // 0: even parity, 1 stop; 1: odd parity, 2 stop; 2: no parity, 1 stop
  uart_tx_frame_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in), .parity_bit_in(parity_bit_in),
    .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
  uart_tx_frame_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in), .parity_bit_in(parity_bit_in),
    .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
  uart_tx_frame_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst(rst), .tx_start(tx_start), .data_in(data_in), .parity_bit_in(parity_bit_in),
    .tx_out(tx_out[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit model_on = 1'b0;

  function automatic int cfg_pe(input int i);
    return (i == 2) ? 0 : 1;
  endfunction
  function automatic logic cfg_po(input int i);
    return (i == 1);
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Line bits of a whole frame, index 0 = start bit; unused upper positions stay high (stop/idle).
  function automatic logic [11:0] frame_bits(input int i, input logic [7:0] d, input logic p);
    logic [11:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int j = 0; j < 8; j++) b[j+1] = d[j];
    if (cfg_pe(i) != 0) b[9] = p ^ cfg_po(i);
    return b;
  endfunction

  logic        act [3];
  int          e   [3];
  int          nb  [3];
  logic [11:0] fb  [3];
  logic        exp_out [3];
  logic        exp_busy[3];
  logic        exp_done[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; e[i] = 0; nb[i] = 0; fb[i] = '1;
      exp_out[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
    end
  end

  // Expected outputs after edge cyc, from the accept edge and the bit-window arithmetic.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        act[i] = 1'b0;
        exp_out[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
        model_on = 1'b1;
      end else begin
        if (act[i] && cyc > e[i] && cyc <= e[i] + nb[i]*C) begin
          exp_out[i]  = fb[i][(cyc - e[i] - 1) / C];
          exp_busy[i] = 1'b1;
        end else begin
          exp_out[i]  = 1'b1;
          exp_busy[i] = 1'b0;
        end
        exp_done[i] = act[i] && (cyc == e[i] + nb[i]*C);
        if (tx_start && (!act[i] || cyc > e[i] + nb[i]*C)) begin
          act[i] = 1'b1;
          e[i]   = cyc;
          fb[i]  = frame_bits(i, data_in, parity_bit_in);
          nb[i]  = 9 + cfg_pe(i) + cfg_sb(i);
        end
      end
    end
  end

  task automatic chk(input string name, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s edge %0d: got %b expected %b", name, cyc, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tx_out[%0d]", i),  tx_out[i],  exp_out[i]);
        chk($sformatf("tx_busy[%0d]", i), tx_busy[i], exp_busy[i]);
        chk($sformatf("tx_done[%0d]", i), tx_done[i], exp_done[i]);
      end
    end
  end

  // Send one byte and check instance inst against a hand-written bit sequence and done timing.
  task automatic run_frame_lit(input int inst, input logic [7:0] d, input logic [11:0] lit, input int n);
    int ea;
    @(negedge clk);
    tx_start = 1'b1; data_in = d; parity_bit_in = ^d;
    @(negedge clk);
    ea = cyc;
    tx_start = 1'b0; data_in = 8'($urandom); parity_bit_in = 1'($urandom);
    for (int t = ea + 1; t <= ea + n*C + 1; t++) begin
      @(negedge clk);
      if (t <= ea + n*C && (t - ea - 1) % C == 1)
        chk($sformatf("lit_bit%0d[%0d]", (t - ea - 1) / C, inst), tx_out[inst], lit[(t - ea - 1) / C]);
      if (t == ea + n*C) chk($sformatf("lit_done[%0d]", inst), tx_done[inst], 1'b1);
      if (t == ea + n*C + 1) begin
        chk($sformatf("lit_busy_low[%0d]", inst), tx_busy[inst], 1'b0);
        chk($sformatf("lit_done_low[%0d]", inst), tx_done[inst], 1'b0);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin : stim
    int ea;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_out", tx_out[0], 1'b1);
    chk("idle_busy", tx_busy[0], 1'b0);

    run_frame_lit(0, 8'h55, 12'b010010101010, 11);
    run_frame_lit(1, 8'h07, 12'b110000001110, 12);
    run_frame_lit(2, 8'hA3, 12'b001101000110, 10);

    // ignored start while busy, then a held start picked up at the first idle edge
    @(negedge clk);
    tx_start = 1'b1; data_in = 8'h5A; parity_bit_in = ^data_in;
    @(negedge clk);
    ea = cyc;
    tx_start = 1'b0;
    while (cyc < ea + 9) @(negedge clk);
    tx_start = 1'b1; data_in = 8'hFF; parity_bit_in = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    while (cyc < ea + 20) @(negedge clk);
    tx_start = 1'b1; data_in = 8'h3C; parity_bit_in = ^data_in;
    while (cyc < ea + 44) @(negedge clk);
    chk("b2b_done", tx_done[0], 1'b1);
    @(negedge clk);
    chk("b2b_busy_gap", tx_busy[0], 1'b0);
    tx_start = 1'b0;
    @(negedge clk);
    chk("b2b_start_bit", tx_out[0], 1'b0);
    chk("b2b_busy_again", tx_busy[0], 1'b1);
    repeat (60) @(negedge clk);

    // reset in the middle of a frame
    @(negedge clk);
    tx_start = 1'b1; data_in = 8'h5A; parity_bit_in = ^data_in;
    @(negedge clk);
    ea = cyc;
    tx_start = 1'b0;
    while (cyc < ea + 17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", tx_out[0], 1'b1);
    chk("midrst_busy", tx_busy[0], 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_frame_lit(0, 8'h81, 12'b010100000010, 11);

    // reset and start on the same edge: nothing accepted
    @(negedge clk);
    rst = 1'b1; tx_start = 1'b1; data_in = 8'h12; parity_bit_in = ^data_in;
    @(negedge clk);
    rst = 1'b0; tx_start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", tx_busy[0], 1'b0);
    chk("rst_start_out", tx_out[0], 1'b1);
    repeat (5) @(negedge clk);

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      tx_start      = ($urandom % 6 == 0);
      data_in       = 8'($urandom);
      parity_bit_in = ($urandom % 4 == 0) ? ~^data_in : ^data_in;
      rst           = ($urandom % 250 == 0);
    end
    @(negedge clk);
    rst = 1'b0; tx_start = 1'b0;
    repeat (60) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
